// File: rtl/iq_readout_engine.sv
// iq_readout_engine
// Trigger-driven I/Q readout: sums LANES rotated samples per valid beat over a
// delayed integration window, optionally averages 2^N shots, and returns one
// saturating I/Q result per measurement over a valid/ready handshake.
//
// Ports
//   clk100       : single clock, rising edge
//   reset        : asynchronous, active-low, clears all state
//   trigger      : one-cycle shot start pulse
//   cfg_delay    : cycles from trigger to window open
//   cfg_length   : window length in valid beats (0 behaves as 1)
//   cfg_avg      : log2 of shots averaged (values above 8 clamp to 8)
//   data_valid   : lanes valid this cycle
//   data_i/q     : packed signed lanes, lane 0 in the LSBs
//   busy         : high in every state except idle
//   res_valid/ready, res_i/q, res_sat : result handshake and payload
//   missed_trig  : count of ignored triggers, saturating at 255
module iq_readout_engine #(
  parameter int unsigned LANES  = 5,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk100,
  input  logic                    reset,
  input  logic                    trigger,
  input  logic [CNT_W-1:0]        cfg_delay,
  input  logic [CNT_W-1:0]        cfg_length,
  input  logic [3:0]              cfg_avg,
  input  logic                    data_valid,
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [LANES*DATA_W-1:0] data_q,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        res_i,
  output logic [ACC_W-1:0]        res_q,
  output logic                    res_sat,
  output logic [7:0]              missed_trig
);

  localparam int unsigned SumW  = DATA_W + $clog2(LANES);
  localparam int unsigned AccXW = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StDelay     = 3'd1;
  localparam logic [2:0] StIntegrate = 3'd2;
  localparam logic [2:0] StDrain     = 3'd3;
  localparam logic [2:0] StArm       = 3'd4;
  localparam logic [2:0] StResult    = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        delay_q, len_q;
  logic [3:0]              avg_q;
  logic [CNT_W-1:0]        delay_cnt_q, win_cnt_q;
  logic [1:0]              drain_cnt_q;
  logic [8:0]              shot_cnt_q;
  logic                    s1_valid_q;
  logic signed [SumW-1:0]  s1_i_q, s1_q_q;
  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic                    sat_i_q, sat_q_q;
  logic [ACC_W-1:0]        res_i_q, res_q_q;
  logic                    res_sat_q;
  logic [7:0]              missed_q;

  logic                    start_new, start_shot, missed, beat;
  logic                    drain_done, more_shots;
  logic [CNT_W-1:0]        len_eff, delay_sel, len_sel;
  logic [3:0]              avg_eff;
  logic [8:0]              shot_next, shot_target;
  logic signed [SumW-1:0]  sum_i, sum_q;
  logic signed [DATA_W-1:0] lane_i, lane_q;
  logic [ACC_W:0]          add_i, add_q;

  // Saturating accumulate; MSB of the return value flags an overflow.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                             input logic signed [SumW-1:0]  s);
    logic signed [ACC_W:0] full;
    full = AccXW'(acc) + AccXW'(s);
    if (full[ACC_W] != full[ACC_W-1]) begin
      return {1'b1, full[ACC_W] ? AccMin : AccMax};
    end
    return {1'b0, full[ACC_W-1:0]};
  endfunction

  assign len_eff     = (cfg_length == '0) ? CNT_W'(1) : cfg_length;
  assign avg_eff     = (cfg_avg > 4'd8) ? 4'd8 : cfg_avg;
  assign shot_next   = shot_cnt_q + 9'd1;
  assign shot_target = 9'd1 << avg_q;
  assign more_shots  = shot_next < shot_target;
  assign drain_done  = (drain_cnt_q == 2'd2);
  assign beat        = (state_q == StIntegrate) && data_valid;

  // A new measurement latches fresh config; a further shot reuses the shadow copy.
  assign delay_sel = start_new ? cfg_delay : delay_q;
  assign len_sel   = start_new ? len_eff : len_q;

  always_comb begin
    state_d    = state_q;
    start_new  = 1'b0;
    start_shot = 1'b0;
    case (state_q)
      StIdle: begin
        if (trigger) start_new = 1'b1;
      end
      StDelay: begin
        if (delay_cnt_q <= CNT_W'(1)) state_d = StIntegrate;
      end
      StIntegrate: begin
        if (data_valid && (win_cnt_q == CNT_W'(1))) state_d = StDrain;
      end
      StDrain: begin
        if (drain_done) state_d = more_shots ? StArm : StResult;
      end
      StArm: begin
        if (trigger) start_shot = 1'b1;
      end
      StResult: begin
        if (res_ready) begin
          state_d = StIdle;
          if (trigger) start_new = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start_new || start_shot) begin
      state_d = (delay_sel == '0) ? StIntegrate : StDelay;
    end
  end

  assign missed = trigger && !(start_new || start_shot);

  always_comb begin
    sum_i  = '0;
    sum_q  = '0;
    lane_i = '0;
    lane_q = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      lane_i = data_i[k*DATA_W +: DATA_W];
      lane_q = data_q[k*DATA_W +: DATA_W];
      sum_i  = sum_i + SumW'(lane_i);
      sum_q  = sum_q + SumW'(lane_q);
    end
  end

  assign add_i = sat_add(acc_i_q, s1_i_q);
  assign add_q = sat_add(acc_q_q, s1_q_q);

  // Control and counters.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      delay_q     <= '0;
      len_q       <= '0;
      avg_q       <= '0;
      delay_cnt_q <= '0;
      win_cnt_q   <= '0;
      drain_cnt_q <= '0;
      shot_cnt_q  <= '0;
      missed_q    <= '0;
    end else begin
      state_q <= state_d;
      if (missed && (missed_q != 8'hFF)) missed_q <= missed_q + 8'd1;
      if (start_new) begin
        delay_q    <= cfg_delay;
        len_q      <= len_eff;
        avg_q      <= avg_eff;
        shot_cnt_q <= '0;
      end
      if (start_new || start_shot) begin
        delay_cnt_q <= delay_sel;
        win_cnt_q   <= len_sel;
      end else if (state_q == StDelay) begin
        delay_cnt_q <= delay_cnt_q - CNT_W'(1);
      end else if (beat) begin
        win_cnt_q <= win_cnt_q - CNT_W'(1);
      end
      if (state_q == StDrain) begin
        if (drain_done) begin
          drain_cnt_q <= '0;
          shot_cnt_q  <= shot_next;
        end else begin
          drain_cnt_q <= drain_cnt_q + 2'd1;
        end
      end
    end
  end

  // Two-stage datapath: registered lane sum, then saturating accumulate.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      sat_i_q    <= 1'b0;
      sat_q_q    <= 1'b0;
    end else begin
      s1_valid_q <= beat;
      if (beat) begin
        s1_i_q <= sum_i;
        s1_q_q <= sum_q;
      end
      if (start_new) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
        sat_i_q <= 1'b0;
        sat_q_q <= 1'b0;
      end else if (s1_valid_q) begin
        // A saturated channel holds its clamp value until the next measurement.
        if (!sat_i_q) begin
          acc_i_q <= add_i[ACC_W-1:0];
          sat_i_q <= add_i[ACC_W];
        end
        if (!sat_q_q) begin
          acc_q_q <= add_q[ACC_W-1:0];
          sat_q_q <= add_q[ACC_W];
        end
      end
    end
  end

  // Result registers change only when entering the result state.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      res_i_q   <= '0;
      res_q_q   <= '0;
      res_sat_q <= 1'b0;
    end else if ((state_q == StDrain) && drain_done && !more_shots) begin
      res_i_q   <= acc_i_q >>> avg_q;
      res_q_q   <= acc_q_q >>> avg_q;
      res_sat_q <= sat_i_q | sat_q_q;
    end
  end

  assign busy        = (state_q != StIdle);
  assign res_valid   = (state_q == StResult);
  assign res_i       = res_i_q;
  assign res_q       = res_q_q;
  assign res_sat     = res_sat_q;
  assign missed_trig = missed_q;

endmodule

// File: tb/tb_iq_readout_engine.sv
// Scoreboard bench for iq_readout_engine: the stimulus side drives shots and
// pushes model results into a queue; a monitor pops on each handshake.
module tb_iq_readout_engine;
  localparam int LANES  = 5;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                    clk100 = 1'b0;
  logic                    reset = 1'b0;
  logic                    trigger = 1'b0;
  logic [CNT_W-1:0]        cfg_delay = '0;
  logic [CNT_W-1:0]        cfg_length = '0;
  logic [3:0]              cfg_avg = '0;
  logic                    data_valid = 1'b0;
  logic [LANES*DATA_W-1:0] data_i = '0;
  logic [LANES*DATA_W-1:0] data_q = '0;
  logic                    busy, res_valid, res_sat;
  logic                    res_ready = 1'b0;
  logic [ACC_W-1:0]        res_i, res_q;
  logic [7:0]              missed_trig;

  iq_readout_engine #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk100     (clk100),
    .reset      (reset),
    .trigger    (trigger),
    .cfg_delay  (cfg_delay),
    .cfg_length (cfg_length),
    .cfg_avg    (cfg_avg),
    .data_valid (data_valid),
    .data_i     (data_i),
    .data_q     (data_q),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_i      (res_i),
    .res_q      (res_q),
    .res_sat    (res_sat),
    .missed_trig(missed_trig)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    longint ri;
    longint rq;
    bit     sat;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  int     m_delay, m_len, m_avg;
  int     lane_mode, ci, cq;
  bit     gaps, allow_l3;
  int     missed_exp;
  longint acc_i, acc_q;
  bit     sat_i, sat_q;
  int     li[LANES];
  int     lq[LANES];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk100);
    #1;
  endtask

  function automatic int rnd_lane();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Reference accumulate: plain wide arithmetic, clamped, sticky per channel.
  function automatic void acc_add(inout longint acc, inout bit sat, input longint s);
    if (sat) return;
    acc = acc + s;
    if (acc > MAXV) begin
      acc = MAXV;
      sat = 1'b1;
    end else if (acc < MINV) begin
      acc = MINV;
      sat = 1'b1;
    end
  endfunction

  // kind 0: invalid cycle, 1: counted beat, 2: valid data the DUT must ignore.
  task automatic drive(input int kind, input int shot);
    longint si = 0;
    longint sq = 0;
    for (int k = 0; k < LANES; k++) begin
      if (kind == 1 && lane_mode == 1) begin
        li[k] = ci;
        lq[k] = cq;
      end else if (kind == 1 && lane_mode == 2) begin
        li[k] = shot + 1;
        lq[k] = -7;
      end else begin
        li[k] = rnd_lane();
        lq[k] = rnd_lane();
      end
      data_i[k*DATA_W +: DATA_W] = DATA_W'(li[k]);
      data_q[k*DATA_W +: DATA_W] = DATA_W'(lq[k]);
      si += longint'(li[k]);
      sq += longint'(lq[k]);
    end
    data_valid = (kind != 0);
    if (kind == 1) begin
      acc_add(acc_i, sat_i, si);
      acc_add(acc_q, sat_q, sq);
    end
  endtask

  task automatic set_cfg(input int d, input int l, input int a);
    cfg_delay  = CNT_W'(d);
    cfg_length = CNT_W'(l);
    cfg_avg    = 4'(a);
    m_delay    = d;
    m_len      = (l == 0) ? 1 : l;
    m_avg      = (a > 8) ? 8 : a;
  endtask

  // Runs every shot of one measurement; pretrig means shot 0 was already triggered.
  task automatic run_meas(input bit pretrig);
    int   shots = 1 << m_avg;
    int   k;
    bit   last, l3;
    exp_t e;
    acc_i = 0;
    acc_q = 0;
    sat_i = 0;
    sat_q = 0;
    for (int s = 0; s < shots; s++) begin
      last = (s == shots - 1);
      if (!(pretrig && s == 0)) begin
        trigger = 1'b1;
        drive(2, s);
        cyc();
        trigger = 1'b0;
      end
      if (s == 0) begin
        // Config scrambled after the latch must not affect this measurement.
        cfg_delay  = CNT_W'($urandom);
        cfg_length = CNT_W'($urandom);
        cfg_avg    = 4'($urandom);
      end
      for (int d = 0; d < m_delay; d++) begin
        drive($urandom_range(1) ? 2 : 0, s);
        cyc();
      end
      k = 0;
      while (k < m_len) begin
        if (gaps && $urandom_range(1) == 1) begin
          drive(0, s);
          cyc();
        end else begin
          drive(1, s);
          cyc();
          k++;
        end
      end
      drive(2, s);
      cyc();
      drive(2, s);
      cyc();
      if (last) check("res_valid_early", longint'(res_valid), 0);
      check("busy_drain", longint'(busy), 1);
      l3 = !last && allow_l3 && ($urandom_range(3) == 0);
      if (l3) begin
        trigger = 1'b1;
        missed_exp++;
      end
      drive(2, s);
      cyc();
      trigger = 1'b0;
      if (last) check("res_valid_rise", longint'(res_valid), 1);
      else check("busy_arm", longint'(busy), 1);
      if (!last) begin
        repeat ($urandom_range(2)) begin
          drive(2, s);
          cyc();
        end
      end
    end
    e.ri  = acc_i >>> m_avg;
    e.rq  = acc_q >>> m_avg;
    e.sat = sat_i | sat_q;
    sb_q.push_back(e);
  endtask

  task automatic finish_meas(input int stalls, input bit stall_trig, input bit trig_hs);
    res_ready = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      check("hold_valid", longint'(res_valid), 1);
      if (sb_q.size() > 0) check("hold_res_i", longint'($signed(res_i)), sb_q[0].ri);
      if (stall_trig) begin
        trigger = 1'b1;
        missed_exp++;
      end
      drive(0, 0);
      cyc();
      trigger = 1'b0;
    end
    res_ready = 1'b1;
    trigger   = trig_hs;
    drive(0, 0);
    cyc();
    res_ready = 1'b0;
    trigger   = 1'b0;
    check("busy_after_hs", longint'(busy), longint'(trig_hs));
    check("valid_after_hs", longint'(res_valid), 0);
    check("missed_after_hs", longint'(missed_trig), longint'(missed_exp));
  endtask

  // Monitor: one comparison set per completed handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk100);
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0d required=none", $signed(res_i));
        end else begin
          e = sb_q.pop_front();
          check("res_i", longint'($signed(res_i)), e.ri);
          check("res_q", longint'($signed(res_q)), e.rq);
          check("res_sat", longint'(res_sat), longint'(e.sat));
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_valid"}, longint'(res_valid), 0);
    check({tag, "_res_i"}, longint'(res_i), 0);
    check({tag, "_res_q"}, longint'(res_q), 0);
    check({tag, "_sat"}, longint'(res_sat), 0);
    check({tag, "_missed"}, longint'(missed_trig), 0);
  endtask

  initial begin
    missed_exp = 0;
    allow_l3   = 1'b0;
    gaps       = 1'b0;
    #2;
    check_reset_values("reset");
    cyc();
    reset = 1'b1;
    cyc();

    // Basic window.
    lane_mode = 1;
    ci        = 100;
    cq        = -50;
    set_cfg(3, 4, 0);
    run_meas(1'b0);
    check("basic_i", longint'($signed(res_i)), 2000);
    check("basic_q", longint'($signed(res_q)), -1000);
    finish_meas(0, 1'b0, 1'b0);

    // Gapped valid.
    gaps = 1'b1;
    set_cfg(3, 4, 0);
    run_meas(1'b0);
    check("gapped_i", longint'($signed(res_i)), 2000);
    check("gapped_q", longint'($signed(res_q)), -1000);
    finish_meas(1, 1'b0, 1'b0);
    gaps = 1'b0;

    // Averaging over four shots.
    lane_mode = 2;
    set_cfg(2, 1, 2);
    run_meas(1'b0);
    check("avg_i", longint'($signed(res_i)), 12);
    check("avg_q", longint'($signed(res_q)), -35);
    finish_meas(0, 1'b0, 1'b0);

    // Saturation.
    lane_mode = 1;
    ci        = 32767;
    cq        = -32768;
    set_cfg(1, 20000, 0);
    run_meas(1'b0);
    check("sat_i", longint'($signed(res_i)), MAXV);
    check("sat_q", longint'($signed(res_q)), MINV);
    check("sat_flag", longint'(res_sat), 1);
    finish_meas(0, 1'b0, 1'b0);

    // Backpressure with missed triggers, then trigger on the handshake cycle.
    ci = 100;
    cq = -50;
    set_cfg(3, 4, 0);
    run_meas(1'b0);
    lane_mode = 0;
    set_cfg(2, 3, 1);
    finish_meas(3, 1'b1, 1'b1);
    check("missed_three", longint'(missed_trig), 3);
    run_meas(1'b1);
    finish_meas(0, 1'b0, 1'b0);

    // Reset mid-integration discards everything.
    lane_mode = 1;
    set_cfg(3, 10, 0);
    trigger = 1'b1;
    drive(2, 0);
    cyc();
    trigger = 1'b0;
    repeat (5) begin
      drive(1, 0);
      cyc();
    end
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    missed_exp = 0;
    cyc();
    reset = 1'b1;
    cyc();
    set_cfg(3, 4, 0);
    run_meas(1'b0);
    check("post_reset_i", longint'($signed(res_i)), 2000);
    check("post_reset_q", longint'($signed(res_q)), -1000);
    finish_meas(0, 1'b0, 1'b0);

    // Randomized measurements, including zero delay and zero length.
    allow_l3  = 1'b1;
    lane_mode = 0;
    for (int n = 0; n < 14; n++) begin
      gaps = 1'(($urandom_range(1)));
      set_cfg(int'($urandom_range(5)), int'($urandom_range(6)), int'($urandom_range(3)));
      run_meas(1'b0);
      finish_meas(int'($urandom_range(2)), 1'(($urandom_range(1))), 1'b0);
    end

    // cfg_avg above 8 clamps to 256 shots.
    gaps = 1'b0;
    set_cfg(0, 1, 9);
    run_meas(1'b0);
    finish_meas(0, 1'b0, 1'b0);

    drive(0, 0);
    repeat (3) cyc();
    check("scoreboard_empty", longint'(sb_q.size()), 0);
    check("missed_final", longint'(missed_trig), longint'(missed_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
